// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - two-requester I2C register transaction arbiter
//
// Arbitrates two requesters onto one shared I2C byte engine. Each granted
// request becomes a register write (START, dev+W, reg, data, STOP) or a
// register read (START, dev+W, reg, RESTART, dev+R, READ, STOP). One
// completion pulse is returned per transaction.
//
// Ports:
//   scl_4x          system clock, all logic on rising edge
//   rst             synchronous active-high reset
//   req_valid[1:0]  per-requester transaction request
//   req_ready[1:0]  one-cycle grant pulse to the accepted requester
//   req_rw[1:0]     per requester: 0 = write, 1 = read
//   req_dev[1:0]    per-requester 7-bit slave address
//   req_reg[1:0]    per-requester register address
//   req_wdata[1:0]  per-requester write byte
//   cmd_valid       command to byte engine valid (held until cmd_ready)
//   cmd_ready       engine accepts the command
//   cmd_op          000 START, 001 WRITE, 010 READ, 011 RESTART, 100 STOP
//   cmd_data        byte for WRITE, else 0
//   cmd_nack_last   READ: master NACKs the byte
//   eng_done        one-cycle pulse, accepted command finished
//   eng_nack        with eng_done: slave NACKed a WRITE
//   eng_rdata       with eng_done on READ: received byte
//   rsp_valid       one-cycle completion pulse
//   rsp_id          requester owning the response
//   rsp_nack        aborted by NACK or watchdog
//   rsp_timeout     aborted by the watchdog
//   rsp_rdata       read byte, 0 for writes and aborts
//   busy            high from grant until the completion pulse has been sent
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to enable an 8-bit command
// watchdog. Without it the block waits indefinitely and rsp_timeout is 0.

module i2c_txn_arbiter (
  input  logic            scl_4x,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_rw,
  input  logic [1:0][6:0] req_dev,
  input  logic [1:0][7:0] req_reg,
  input  logic [1:0][7:0] req_wdata,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [2:0]      cmd_op,
  output logic [7:0]      cmd_data,
  output logic            cmd_nack_last,
  input  logic            eng_done,
  input  logic            eng_nack,
  input  logic [7:0]      eng_rdata,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic            rsp_nack,
  output logic            rsp_timeout,
  output logic [7:0]      rsp_rdata,
  output logic            busy
);

  localparam logic [2:0] OP_START   = 3'b000;
  localparam logic [2:0] OP_WRITE   = 3'b001;
  localparam logic [2:0] OP_READ    = 3'b010;
  localparam logic [2:0] OP_RESTART = 3'b011;
  localparam logic [2:0] OP_STOP    = 3'b100;

  typedef enum logic [3:0] {
    IDLE, START, DEVW, REGA, WDATA, RESTART, DEVR, RDATA, STOP, RESP
  } state_e;

  state_e     state_q;
  logic       last_q;
  logic       id_q;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       nack_q;

  logic [1:0] req_ready_q;
  logic       cmd_valid_q;
  logic [2:0] cmd_op_q;
  logic [7:0] cmd_data_q;
  logic       cmd_nack_last_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic       rsp_nack_q;
  logic [7:0] rsp_rdata_q;
  logic       busy_q;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       tmo_q;
  logic       rsp_timeout_q;
`endif

  logic       grant_valid;
  logic       grant_id;
  logic       in_cmd_state;
  logic       done_ok;
  logic       write_nack;
  logic       wdog_abort;
  state_e     step_d;
  state_e     issue_d;
  logic [2:0] nop_d;
  logic [7:0] ndata_d;
  logic       nnl_d;

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    grant_valid = |req_valid;
    grant_id    = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_q;
      default: grant_id = 1'b0;
    endcase
  end

  // eng_done only counts once the command has been handed to the engine.
  assign in_cmd_state = (state_q != IDLE) && (state_q != RESP);
  assign done_ok      = in_cmd_state && !cmd_valid_q && eng_done;
  assign write_nack   = eng_nack && ((state_q == DEVW) || (state_q == REGA) ||
                                     (state_q == WDATA) || (state_q == DEVR));

`ifdef I2C_ARB_TIMEOUT_EN
  // The abort fires on the cycle the counter would reach 255; STOP itself
  // is never watchdogged so the bus is always released.
  assign wdog_abort = in_cmd_state && (state_q != STOP) && !done_ok &&
                      (wdog_q == 8'hFE);
`else
  assign wdog_abort = 1'b0;
`endif

  // Successor state once the current command completes.
  always_comb begin
    step_d = state_q;
    case (state_q)
      START:   step_d = DEVW;
      DEVW:    step_d = eng_nack ? STOP : REGA;
      REGA:    step_d = eng_nack ? STOP : (rw_q ? RESTART : WDATA);
      WDATA:   step_d = STOP;
      RESTART: step_d = DEVR;
      DEVR:    step_d = eng_nack ? STOP : RDATA;
      RDATA:   step_d = STOP;
      STOP:    step_d = RESP;
      default: step_d = state_q;
    endcase
  end

  assign issue_d = wdog_abort ? STOP : step_d;

  // Command fields presented on entry to issue_d.
  always_comb begin
    nop_d   = OP_START;
    ndata_d = 8'h00;
    nnl_d   = 1'b0;
    case (issue_d)
      START:   nop_d = OP_START;
      DEVW:    begin nop_d = OP_WRITE; ndata_d = {dev_q, 1'b0}; end
      REGA:    begin nop_d = OP_WRITE; ndata_d = reg_q; end
      WDATA:   begin nop_d = OP_WRITE; ndata_d = wdata_q; end
      RESTART: nop_d = OP_RESTART;
      DEVR:    begin nop_d = OP_WRITE; ndata_d = {dev_q, 1'b1}; end
      RDATA:   begin nop_d = OP_READ; nnl_d = 1'b1; end
      STOP:    nop_d = OP_STOP;
      default: nop_d = OP_START;
    endcase
  end

  always_ff @(posedge scl_4x) begin
    if (rst) begin
      state_q         <= IDLE;
      last_q          <= 1'b1;
      id_q            <= 1'b0;
      rw_q            <= 1'b0;
      dev_q           <= 7'h00;
      reg_q           <= 8'h00;
      wdata_q         <= 8'h00;
      rdata_q         <= 8'h00;
      nack_q          <= 1'b0;
      req_ready_q     <= 2'b00;
      cmd_valid_q     <= 1'b0;
      cmd_op_q        <= 3'b000;
      cmd_data_q      <= 8'h00;
      cmd_nack_last_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= 1'b0;
      rsp_nack_q      <= 1'b0;
      rsp_rdata_q     <= 8'h00;
      busy_q          <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      wdog_q          <= 8'h00;
      tmo_q           <= 1'b0;
      rsp_timeout_q   <= 1'b0;
`endif
    end else begin
      req_ready_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            req_ready_q     <= grant_id ? 2'b10 : 2'b01;
            last_q          <= grant_id;
            id_q            <= grant_id;
            rw_q            <= req_rw[grant_id];
            dev_q           <= req_dev[grant_id];
            reg_q           <= req_reg[grant_id];
            wdata_q         <= req_wdata[grant_id];
            rdata_q         <= 8'h00;
            nack_q          <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= START;
            cmd_valid_q     <= 1'b1;
            cmd_op_q        <= OP_START;
            cmd_data_q      <= 8'h00;
            cmd_nack_last_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wdog_q          <= 8'h00;
            tmo_q           <= 1'b0;
`endif
          end
        end

        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_id_q    <= 1'b0;
          rsp_nack_q  <= 1'b0;
          rsp_rdata_q <= 8'h00;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
          rsp_timeout_q <= 1'b0;
`endif
        end

        default: begin
          if (done_ok || wdog_abort) begin
            if (done_ok && write_nack) nack_q <= 1'b1;
            if (done_ok && (state_q == RDATA)) rdata_q <= eng_rdata;
            if (issue_d == RESP) begin
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= id_q;
              rsp_nack_q  <= nack_q;
              rsp_rdata_q <= rdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
              rsp_timeout_q <= tmo_q;
`endif
            end else begin
              cmd_valid_q     <= 1'b1;
              cmd_op_q        <= nop_d;
              cmd_data_q      <= ndata_d;
              cmd_nack_last_q <= nnl_d;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            wdog_q <= 8'h00;
            if (wdog_abort) begin
              nack_q <= 1'b1;
              tmo_q  <= 1'b1;
            end
`endif
            state_q <= issue_d;
          end else begin
            if (cmd_valid_q && cmd_ready) begin
              cmd_valid_q     <= 1'b0;
              cmd_op_q        <= 3'b000;
              cmd_data_q      <= 8'h00;
              cmd_nack_last_q <= 1'b0;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            if (state_q != STOP) wdog_q <= wdog_q + 8'h01;
`endif
          end
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_op        = cmd_op_q;
  assign cmd_data      = cmd_data_q;
  assign cmd_nack_last = cmd_nack_last_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_nack      = rsp_nack_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = busy_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign rsp_timeout   = rsp_timeout_q;
`else
  assign rsp_timeout   = 1'b0;
`endif

endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- scl_4x  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester transaction request; bit n = requester n
- req_ready  out  2  one-cycle pulse: requester n's transaction accepted
- req_rw  in  2  per requester: 0 = write, 1 = read
- req_dev  in  2x7  per-requester 7-bit slave address
- req_reg  in  2x8  per-requester register address
- req_wdata  in  2x8  per-requester write byte
- cmd_valid  out  1  command to shared I2C byte engine valid
- cmd_ready  in  1  engine accepts command when cmd_valid and cmd_ready are both high
- cmd_op  out  3  000 START, 001 WRITE, 010 READ, 011 RESTART, 100 STOP
- cmd_data  out  8  byte for WRITE; otherwise 0
- cmd_nack_last  out  1  for READ: master sends NACK after the byte
- eng_done  in  1  one-cycle pulse: accepted command finished
- eng_nack  in  1  valid with eng_done: slave NACKed a WRITE
- eng_rdata  in  8  valid with eng_done on READ
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  1  requester that owns the response
- rsp_nack  out  1  transaction aborted by NACK or timeout
- rsp_timeout  out  1  abort caused by the watchdog
- rsp_rdata  out  8  read byte; 0 for writes and aborts
- busy  out  1  high from grant until rsp_valid

Function
REQ-002 SHALL use the states IDLE, START, DEVW, REGA, WDATA, RESTART, DEVR, RDATA, STOP, RESP.
REQ-003 In IDLE, SHALL grant round-robin among asserted req_valid bits, preferring the requester not granted last; a single requester is granted directly.
REQ-004 On grant, SHALL pulse req_ready[n] for one cycle, latch rw/dev/reg/wdata, assert busy, and enter START the next cycle.
REQ-005 Each state except IDLE and RESP SHALL issue exactly one command, hold cmd_valid and its fields stable until cmd_ready, deassert cmd_valid afterwards, then wait for eng_done.
REQ-006 Write sequence: START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP.
REQ-007 Read sequence: START, WRITE {dev,0}, WRITE reg, RESTART, WRITE {dev,1}, READ with cmd_nack_last=1, STOP; eng_rdata latched on READ done.
REQ-008 eng_nack=1 on any WRITE done SHALL skip the remaining commands, go to STOP, and set rsp_nack=1.
REQ-009 After STOP done, RESP SHALL pulse rsp_valid for one cycle with rsp_id, rsp_nack, rsp_timeout and rsp_rdata, then return to IDLE.
REQ-010 A request arriving or dropping during a transaction SHALL NOT affect it; requests pending in IDLE are arbitrated in the cycle after RESP.
REQ-011 eng_done received while cmd_valid is high or in IDLE/RESP SHALL be ignored.
REQ-012 Grant to the next transaction SHALL occur no earlier than the cycle after rsp_valid; back-to-back requesters alternate.

Reset
REQ-013 While rst is high: state=IDLE; req_ready, cmd_valid, cmd_op, cmd_data, cmd_nack_last, rsp_* and busy all 0; last-grant pointer = 1 (requester 0 wins first tie).
REQ-014 Reset mid-transaction SHALL abandon it without issuing STOP and without asserting rsp_valid.

Configuration
REQ-015 With I2C_ARB_TIMEOUT_EN defined: an 8-bit watchdog clears on each command issue and counts while waiting for cmd_ready or eng_done; reaching 255 aborts to STOP (STOP is itself not watchdogged) with rsp_nack=1 and rsp_timeout=1.
REQ-016 Without I2C_ARB_TIMEOUT_EN, the block SHALL wait indefinitely and rsp_timeout SHALL be tied to 0.

Verification
REQ-017 req0 write dev=0x50 reg=0x92 wdata=0xAC, engine acks all -> ops START, WRITE 0xA0, WRITE 0x92, WRITE 0xAC, STOP; rsp_id=0, rsp_nack=0.
REQ-018 req1 read dev=0x50 reg=0x92, eng_rdata=0x5A -> START, WRITE 0xA0, WRITE 0x92, RESTART, WRITE 0xA1, READ (nack_last=1), STOP; rsp_rdata=0x5A.
REQ-019 Both requesters valid in the same cycle after reset -> req0 granted first, req1 second; repeated contention alternates 0,1,0,1.
REQ-020 eng_nack=1 on the device-address WRITE -> next op is STOP; rsp_nack=1, rsp_rdata=0.
REQ-021 rst asserted during the REGA wait -> next cycle all outputs 0, no rsp_valid; a new request is granted normally.
REQ-022 TIMEOUT_EN defined, eng_done withheld after WRITE 0xA0 -> STOP issued after 255 cycles; rsp_nack=1, rsp_timeout=1.
